tank_plant: RTL
===============

# tank_plant

Behavioural-synthesizable model of the water tank that the pump controller drives. It consumes the pump commands B1/B2, integrates inflow and drain into a level register, and produces the debounced lower (I) and upper (S) level-sensor signals. It is the sensor-side counterpart of the tank controller. In closed-loop benches and on the FPGA demo, the controller's B1/B2 outputs connect to this block and its I/S outputs connect back to the controller.

## Interface

Parameters:
- LEVEL_W, default 8: level register width. Maximum level is 2^LEVEL_W-1.
- INIT_LEVEL, default 0: level loaded on reset.
- LOW_TH, default 64: level at or above which the raw lower sensor is 1.
- HIGH_TH, default 192: level at or above which the raw upper sensor is 1. Requires LOW_TH < HIGH_TH.
- FILL_STEP, default 4: units added per cycle per active pump.
- DRAIN_STEP, default 2: units removed per drain tick.
- DRAIN_PERIOD, default 2: cycles between drain ticks. Must be ≥1.
- DEB_CYCLES, default 3: consecutive cycles a raw sensor must disagree with its output before the output changes. Must be ≥1.

Ports:
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high.
- B1, input, 1: pump 1 on.
- B2, input, 1: pump 2 on.
- drain_en, input, 1: consumer draw enabled.
- clr_flags, input, 1: clears the sticky overflow and dry flags.
- fault_i_stuck0, input, 1: forces I to 0. Effective only with the fault macro.
- fault_s_stuck1, input, 1: forces S to 1. Effective only with the fault macro.
- I, output, 1: debounced lower sensor.
- S, output, 1: debounced upper sensor.
- level, output, LEVEL_W: current level, registered.
- overflow, output, 1: sticky; a computed level exceeded the maximum.
- dry, output, 1: sticky; a computed level went below 0.

## Operation

- Drain tick counter:
  - Free-running, counts 0..DRAIN_PERIOD-1 and wraps.
  - Runs regardless of drain_en.
  - tick = 1 while the counter equals DRAIN_PERIOD-1.
- Level update, every cycle:
  - next = level + (B1+B2)·FILL_STEP − (tick & drain_en)·DRAIN_STEP.
  - Computed signed at LEVEL_W+2 bits.
  - Inflow and outflow in the same cycle net out.
- Saturation:
  - next > 2^LEVEL_W−1: level is set to the maximum and overflow is set.
  - next < 0: level is set to 0 and dry is set.
- Flags:
  - Sticky until clr_flags or reset.
  - If clr_flags and a set condition occur in the same cycle, set wins.
- Raw sensors, combinational from the registered level:
  - rawI = (level ≥ LOW_TH).
  - rawS = (level ≥ HIGH_TH).
- Debouncer, one per sensor, using a counter of ceil(log2(DEB_CYCLES+1)) bits:
  - raw == out: counter is cleared.
  - raw != out and counter == DEB_CYCLES−1: out takes raw and counter is cleared.
  - Otherwise: counter increments.
  - A disagreement shorter than DEB_CYCLES cycles never reaches the output.
- States: the level register plus the two debouncers. Each debouncer has two states, STABLE (counter 0) and PENDING (counter > 0), with transitions as above.
- Since LOW_TH < HIGH_TH, the raw pair never shows I=0,S=1. That pair appears only through fault injection or debounce skew during fast transients.

## Timing

- Reset values:
  - level = INIT_LEVEL.
  - I = (INIT_LEVEL ≥ LOW_TH), S = (INIT_LEVEL ≥ HIGH_TH).
  - Debounce counters, drain counter, overflow and dry all 0.
- Reset mid-operation discards all in-flight debounce and drain progress on that edge.
- B1/B2/drain_en are sampled at edge N. level reflects them after edge N.
- A level crossing a threshold at edge N changes the sensor output at edge N+DEB_CYCLES.
- Pump-to-sensor latency is therefore DEB_CYCLES edges after the edge where level crosses.
- overflow and dry assert on the same edge the saturated level is written.
- All outputs are registered, except the fault forcing described below.

## Configuration

- Macro TANK_PLANT_FAULT_INJ_EN.
- Defined:
  - I = I_deb & ~fault_i_stuck0 and S = S_deb | fault_s_stuck1, applied combinationally at the output.
  - Debouncer state is unaffected, so releasing a fault restores the true value in the same cycle.
- Undefined:
  - Fault inputs are ignored; I and S are the debouncer registers.
  - The ports remain present.

## Test plan

All scenarios use default parameters.

1. Reset with INIT_LEVEL=0 -> level=0, I=0, S=0, overflow=0, dry=0 on the first edge after reset.
2. From level 0, hold B1=B2=1 with drain_en=0 -> level rises +8 per edge. level=64 after edge 8, I=1 after edge 11. level=192 after edge 24, S=1 after edge 27.
3. Level 248 with B1=B2=1 -> next edge level=255 and overflow=1. overflow stays 1 with pumps off until clr_flags=1 for one cycle, then clears.
4. Level 60 with B1=1 for one cycle -> level 64. Then drain_en=1 and pumps off so the level returns below 64 within 2 cycles -> I never asserts.
5. Level 2, drain_en=1, pumps off -> level 0 after the next tick. At the following tick level stays 0 and dry=1.
6. Level 100 (I=1, S=0), assert fault_i_stuck0 and fault_s_stuck1 -> with the macro, I=0 and S=1 in the same cycle and return to 1/0 on release. Without the macro, I/S stay 1/0.

Source files
------------

// File: rtl/tank_plant_if.sv
// ---------------------------------------------------------------------------
// tank_plant_if
//
// Purpose: bundles the signals exchanged between the pump controller (or a
// bench standing in for it) and the tank plant model.
//
// Signals:
//   B1, B2          pump commands (controller -> plant)
//   drain_en        consumer draw enable (controller/bench -> plant)
//   clr_flags       clears the sticky overflow/dry flags
//   fault_i_stuck0  forces I low  (only honoured with TANK_PLANT_FAULT_INJ_EN)
//   fault_s_stuck1  forces S high (only honoured with TANK_PLANT_FAULT_INJ_EN)
//   I, S            debounced lower/upper level sensors (plant -> controller)
//   level           registered tank level
//   overflow, dry   sticky saturation flags
//
// Modports: master = controller/bench side, slave = plant side.
// ---------------------------------------------------------------------------
interface tank_plant_if #(
    parameter int LEVEL_W = 8
);
    logic               B1;
    logic               B2;
    logic               drain_en;
    logic               clr_flags;
    logic               fault_i_stuck0;
    logic               fault_s_stuck1;
    logic               I;
    logic               S;
    logic [LEVEL_W-1:0] level;
    logic               overflow;
    logic               dry;

    modport master (
        output B1, B2, drain_en, clr_flags, fault_i_stuck0, fault_s_stuck1,
        input  I, S, level, overflow, dry
    );

    modport slave (
        input  B1, B2, drain_en, clr_flags, fault_i_stuck0, fault_s_stuck1,
        output I, S, level, overflow, dry
    );
endinterface

// File: rtl/tank_plant.sv
// ---------------------------------------------------------------------------
// tank_plant
//
// Purpose: synthesizable model of the water tank driven by the pump
// controller. Integrates pump inflow and periodic drain into a saturating
// level register, keeps sticky overflow/dry flags and produces debounced
// lower (I) and upper (S) level-sensor outputs.
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high reset
//   bus    tank_plant_if.slave: B1/B2/drain_en/clr_flags/fault inputs,
//          I/S/level/overflow/dry outputs
//
// Optional feature: define TANK_PLANT_FAULT_INJ_EN to let fault_i_stuck0 and
// fault_s_stuck1 override I and S combinationally. Without the macro the
// fault inputs are ignored and I/S come straight from the debouncers.
// ---------------------------------------------------------------------------
module tank_plant #(
    parameter int LEVEL_W      = 8,
    parameter int INIT_LEVEL   = 0,
    parameter int LOW_TH       = 64,
    parameter int HIGH_TH      = 192,
    parameter int FILL_STEP    = 4,
    parameter int DRAIN_STEP   = 2,
    parameter int DRAIN_PERIOD = 2,
    parameter int DEB_CYCLES   = 3
) (
    input  logic         clk,
    input  logic         reset,
    tank_plant_if.slave  bus
);

    localparam int SUM_W     = LEVEL_W + 2;
    localparam int MAX_LEVEL = (1 << LEVEL_W) - 1;
    localparam int DRAIN_W   = (DRAIN_PERIOD > 1) ? $clog2(DRAIN_PERIOD) : 1;
    localparam int DEB_W     = $clog2(DEB_CYCLES + 1);

    // Index 0 is the lower sensor (I), index 1 the upper sensor (S).
    typedef enum logic {STABLE, PENDING} debState_e;

    logic [DRAIN_W-1:0]      drainCnt_q, drainCnt_d;
    logic [LEVEL_W-1:0]      level_q, level_d;
    logic                    overflow_q, overflow_d;
    logic                    dry_q, dry_d;
    logic                    tick;
    logic signed [SUM_W-1:0] nextLevel;
    logic [SUM_W-1:0]        fillAmt, drainAmt;

    debState_e               debState_q [2];
    debState_e               debState_d [2];
    logic [DEB_W-1:0]        debCnt_q   [2];
    logic [DEB_W-1:0]        debCnt_d   [2];
    logic                    debOut_q   [2];
    logic                    debOut_d   [2];
    logic                    rawSens    [2];

    // The drain tick fires on the last count of a free-running period
    // counter that ignores drain_en, so enabling the drain mid-period keeps
    // the tick phase intact.
    always_comb begin
        tick       = (drainCnt_q == DRAIN_W'(DRAIN_PERIOD - 1));
        drainCnt_d = tick ? '0 : drainCnt_q + 1'b1;
    end

    // Level integration is done two bits wider than the level and signed,
    // so a single cycle's over- or under-run is visible before clamping.
    // Flags use set-over-clear priority so a saturation event coinciding
    // with clr_flags is never lost.
    always_comb begin
        fillAmt  = '0;
        drainAmt = '0;
        if (bus.B1) fillAmt = fillAmt + SUM_W'(FILL_STEP);
        if (bus.B2) fillAmt = fillAmt + SUM_W'(FILL_STEP);
        if (tick && bus.drain_en) drainAmt = SUM_W'(DRAIN_STEP);
        nextLevel  = $signed({2'b00, level_q} + fillAmt - drainAmt);

        level_d    = nextLevel[LEVEL_W-1:0];
        overflow_d = overflow_q & ~bus.clr_flags;
        dry_d      = dry_q & ~bus.clr_flags;
        if (nextLevel[SUM_W-1]) begin
            level_d = '0;
            dry_d   = 1'b1;
        end else if (nextLevel > $signed(SUM_W'(MAX_LEVEL))) begin
            level_d    = LEVEL_W'(MAX_LEVEL);
            overflow_d = 1'b1;
        end
    end

    // Debouncer next-state: an output only follows its raw sensor after
    // DEB_CYCLES consecutive disagreeing samples; any agreeing sample
    // returns the debouncer to STABLE with the count cleared.
    always_comb begin
        rawSens[0] = (level_q >= LEVEL_W'(LOW_TH));
        rawSens[1] = (level_q >= LEVEL_W'(HIGH_TH));
        for (int k = 0; k < 2; k++) begin
            debState_d[k] = STABLE;
            debCnt_d[k]   = '0;
            debOut_d[k]   = debOut_q[k];
            if (rawSens[k] == debOut_q[k]) begin
                debState_d[k] = STABLE;
            end else if (debCnt_q[k] == DEB_W'(DEB_CYCLES - 1)) begin
                debOut_d[k]   = rawSens[k];
                debState_d[k] = STABLE;
            end else begin
                debState_d[k] = PENDING;
                case (debState_q[k])
                    STABLE:  debCnt_d[k] = DEB_W'(1);
                    PENDING: debCnt_d[k] = debCnt_q[k] + 1'b1;
                    default: debCnt_d[k] = '0;
                endcase
            end
        end
    end

    // All plant state registers; reset discards any drain or debounce
    // progress and reloads the sensors to match the initial level.
    always_ff @(posedge clk) begin
        if (reset) begin
            drainCnt_q  <= '0;
            level_q     <= LEVEL_W'(INIT_LEVEL);
            overflow_q  <= 1'b0;
            dry_q       <= 1'b0;
            debState_q[0] <= STABLE;
            debState_q[1] <= STABLE;
            debCnt_q[0]   <= '0;
            debCnt_q[1]   <= '0;
            debOut_q[0]   <= (INIT_LEVEL >= LOW_TH);
            debOut_q[1]   <= (INIT_LEVEL >= HIGH_TH);
        end else begin
            drainCnt_q  <= drainCnt_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            dry_q       <= dry_d;
            for (int k = 0; k < 2; k++) begin
                debState_q[k] <= debState_d[k];
                debCnt_q[k]   <= debCnt_d[k];
                debOut_q[k]   <= debOut_d[k];
            end
        end
    end

    assign bus.level    = level_q;
    assign bus.overflow = overflow_q;
    assign bus.dry      = dry_q;

`ifdef TANK_PLANT_FAULT_INJ_EN
    // Forcing sits after the debouncer registers so releasing a fault shows
    // the true debounced value immediately.
    assign bus.I = debOut_q[0] & ~bus.fault_i_stuck0;
    assign bus.S = debOut_q[1] |  bus.fault_s_stuck1;
`else
    logic unusedFaults;
    assign unusedFaults = bus.fault_i_stuck0 ^ bus.fault_s_stuck1;
    assign bus.I = debOut_q[0];
    assign bus.S = debOut_q[1];
`endif

endmodule
